// File: rtl/pdu_pkg.sv
// ============================================================================
// Module      : pdu_pkg
// Description : Types and widths for the PDU generator: descriptor layout,
//               queue index widths and the framing state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdu_pkg;

  localparam int APP_IDX_WIDTH    = 8;
  localparam int FLOW_IDX_WIDTH   = 12;
  localparam int SIZE_FLITS_WIDTH = 8;
  localparam int SIZE_BYTES_WIDTH = 16;

  typedef struct packed {
    logic [APP_IDX_WIDTH-1:0]    dsc_queue_id;
    logic [FLOW_IDX_WIDTH-1:0]   pkt_queue_id;
    logic [SIZE_FLITS_WIDTH-1:0] size_flits;
    logic [SIZE_BYTES_WIDTH-1:0] size_bytes;
    logic                        trunc;
  } pdu_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PKT  = 2'd1,
    ST_DISCARD = 2'd2
  } pdu_state_e;

endpackage

`default_nettype wire

// File: rtl/shared_struct_pkg.sv
// ============================================================================
// Module      : shared_struct_pkg
// Description : Structures shared across the host RX path. metadata_t is the
//               per-packet record produced by the flow-director stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shared_struct_pkg;

  typedef struct packed {
    logic [15:0] dsc_queue_id;  // descriptor (application) queue index
    logic [15:0] pkt_queue_id;  // packet (flow) queue index
  } metadata_t;

endpackage

`default_nettype wire

// File: rtl/pdu_byte_swap.sv
// ============================================================================
// Module      : pdu_byte_swap
// Description : Combinational flit byte-order reversal. With SWAP_BYTES=1,
//               output byte i is input byte (DATA_WIDTH/8-1-i); with
//               SWAP_BYTES=0 the flit passes straight through.
// Ports       : flit         - input flit
//               flit_swapped - (possibly) byte-reversed flit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdu_byte_swap #(
  parameter int DATA_WIDTH = 512,
  parameter int SWAP_BYTES = 1
) (
  input  logic [DATA_WIDTH-1:0] flit,
  output logic [DATA_WIDTH-1:0] flit_swapped
);

  localparam int c_NBYTES = DATA_WIDTH / 8;

  generate
    if (SWAP_BYTES != 0) begin : g_swap
      for (genvar i = 0; i < c_NBYTES; i++) begin : g_byte
        assign flit_swapped[i*8 +: 8] = flit[(c_NBYTES-1-i)*8 +: 8];
      end
    end else begin : g_pass
      assign flit_swapped = flit;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pdu_gen_mc.sv
// ============================================================================
// Module      : pdu_gen_mc
// Description : Packet-to-PDU writer. Accepts a framed flit stream plus
//               per-packet metadata, writes flits to the packet buffer through
//               a 3-stage pipeline and emits one descriptor per packet
//               (flit/byte size, truncation flag). Truncates oversize packets,
//               recovers from framing errors and keeps statistics.
// Ports       : in_*            - flit stream and metadata (valid/ready)
//               pkt_buf_*       - packet-buffer write port and occupancy
//               desc_buf_*      - descriptor-buffer write port and occupancy
//               stat_*          - packet / truncation / framing-error counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdu_gen_mc
  import shared_struct_pkg::*;
  import pdu_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int PDU_AWIDTH    = 10,
  parameter int PDU_DEPTH     = 1024,
  parameter int MAX_PKT_FLITS = 24,
  parameter int SWAP_BYTES    = 1,
  parameter int PIPE_SLACK    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  output logic                   in_ready,
  input  logic                   in_meta_valid,
  input  metadata_t              in_meta_data,
  output logic                   in_meta_ready,
  output logic                   pkt_buf_wr_en,
  output logic [DATA_WIDTH-1:0]  pkt_buf_wr_data,
  output logic                   pkt_buf_wr_sop,
  output logic                   pkt_buf_wr_eop,
  input  logic [PDU_AWIDTH-1:0]  pkt_buf_occup,
  output logic                   desc_buf_wr_en,
  output pdu_desc_t              desc_buf_wr_data,
  input  logic [PDU_AWIDTH-1:0]  desc_buf_occup,
  output logic [31:0]            stat_pkt_cnt,
  output logic [31:0]            stat_trunc_cnt,
  output logic [31:0]            stat_err_cnt
);

  localparam int c_CNT_W          = $clog2(MAX_PKT_FLITS + 1);
  localparam int c_BYTES_PER_FLIT = DATA_WIDTH / 8;
  localparam int c_PKT_AF_LVL     = PDU_DEPTH - PIPE_SLACK - MAX_PKT_FLITS;
  localparam int c_DSC_AF_LVL     = PDU_DEPTH - PIPE_SLACK - 1;

  pdu_state_e              r_state;
  logic [c_CNT_W-1:0]      r_flit_cnt;
  logic [31:0]             r_stat_pkt, r_stat_trunc, r_stat_err;

  // Stage 1: accepted flit + descriptor built at the closing transfer.
  logic                    r_s1_valid, r_s1_sop, r_s1_eop, r_s1_dvalid;
  logic [DATA_WIDTH-1:0]   r_s1_data;
  pdu_desc_t               r_s1_desc;
  // Stage 2: byte-swapped flit.
  logic                    r_s2_valid, r_s2_sop, r_s2_eop, r_s2_dvalid;
  logic [DATA_WIDTH-1:0]   r_s2_data;
  pdu_desc_t               r_s2_desc;
  // Stage 3: output registers.
  logic                    r_s3_valid, r_s3_sop, r_s3_eop, r_s3_dvalid;
  logic [DATA_WIDTH-1:0]   r_s3_data;
  pdu_desc_t               r_s3_desc;

  logic                    w_almost_full, w_transfer, w_write, w_at_max;
  logic                    w_close, w_trunc, w_err;
  logic [c_CNT_W-1:0]      w_cnt_next;
  logic [DATA_WIDTH-1:0]   w_swapped;
  pdu_desc_t               w_desc;
  logic                    w_meta_unused;

  assign w_almost_full = (32'(pkt_buf_occup)  >= 32'(c_PKT_AF_LVL)) ||
                         (32'(desc_buf_occup) >= 32'(c_DSC_AF_LVL));

  // Discarded flits need no metadata, so only ST_DISCARD bypasses in_meta_valid.
  assign in_ready   = !rst && !w_almost_full &&
                      ((r_state == ST_DISCARD) || in_meta_valid);
  assign w_transfer = in_valid && in_ready;

  // A flit is written when it starts a packet from IDLE or continues one;
  // a mid-packet sop is treated as a continuation.
  assign w_write    = w_transfer &&
                      (((r_state == ST_IDLE) && in_sop) || (r_state == ST_IN_PKT));
  assign w_cnt_next = (r_state == ST_IDLE) ? c_CNT_W'(1) : r_flit_cnt + c_CNT_W'(1);
  assign w_at_max   = (w_cnt_next == c_CNT_W'(MAX_PKT_FLITS));
  assign w_close    = w_write && (in_eop || w_at_max);
  assign w_trunc    = w_write && !in_eop && w_at_max;
  assign w_err      = w_transfer &&
                      (((r_state == ST_IDLE) && !in_sop) ||
                       ((r_state == ST_IN_PKT) && in_sop));

  // One metadata pop per packet, tied to the closing transfer.
  assign in_meta_ready = w_close;

  always_comb begin
    w_desc              = '0;
    w_desc.dsc_queue_id = in_meta_data.dsc_queue_id[APP_IDX_WIDTH-1:0];
    w_desc.pkt_queue_id = in_meta_data.pkt_queue_id[FLOW_IDX_WIDTH-1:0];
    w_desc.size_flits   = SIZE_FLITS_WIDTH'(w_cnt_next);
    // Byte count formed at 32 bits, then reduced to the descriptor field.
    w_desc.size_bytes   = SIZE_BYTES_WIDTH'(32'(w_cnt_next) * 32'(c_BYTES_PER_FLIT)
                          - (w_trunc ? 32'd0 : 32'(in_empty)));
    w_desc.trunc        = w_trunc;
  end

  // Queue index bits above the descriptor field widths are intentionally dropped.
  assign w_meta_unused = ^{in_meta_data.dsc_queue_id[15:APP_IDX_WIDTH],
                           in_meta_data.pkt_queue_id[15:FLOW_IDX_WIDTH]};

  // Framing FSM, counters and stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_flit_cnt   <= '0;
      r_stat_pkt   <= '0;
      r_stat_trunc <= '0;
      r_stat_err   <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_sop     <= 1'b0;
      r_s1_eop     <= 1'b0;
      r_s1_data    <= '0;
      r_s1_dvalid  <= 1'b0;
      r_s1_desc    <= '0;
    end else begin
      r_s1_valid  <= w_write;
      r_s1_dvalid <= w_close;
      if (w_write) begin
        r_s1_data  <= in_data;
        r_s1_sop   <= (r_state == ST_IDLE);
        r_s1_eop   <= in_eop || w_at_max;
        r_flit_cnt <= w_cnt_next;
        if (w_trunc)      r_state <= ST_DISCARD;
        else if (w_close) r_state <= ST_IDLE;
        else              r_state <= ST_IN_PKT;
      end else if (w_transfer && (r_state == ST_DISCARD) && in_eop) begin
        r_state <= ST_IDLE;
      end
      if (w_close) begin
        r_s1_desc  <= w_desc;
        r_stat_pkt <= r_stat_pkt + 32'd1;
      end
      if (w_trunc) r_stat_trunc <= r_stat_trunc + 32'd1;
      if (w_err)   r_stat_err   <= r_stat_err + 32'd1;
    end
  end

  pdu_byte_swap #(
    .DATA_WIDTH (DATA_WIDTH),
    .SWAP_BYTES (SWAP_BYTES)
  ) u_byte_swap (
    .flit         (r_s1_data),
    .flit_swapped (w_swapped)
  );

  // Stages 2 and 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_sop    <= 1'b0;
      r_s2_eop    <= 1'b0;
      r_s2_data   <= '0;
      r_s2_dvalid <= 1'b0;
      r_s2_desc   <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_sop    <= 1'b0;
      r_s3_eop    <= 1'b0;
      r_s3_data   <= '0;
      r_s3_dvalid <= 1'b0;
      r_s3_desc   <= '0;
    end else begin
      r_s2_valid  <= r_s1_valid;
      r_s2_dvalid <= r_s1_dvalid;
      r_s3_valid  <= r_s2_valid;
      r_s3_dvalid <= r_s2_dvalid;
      if (r_s1_valid) begin
        r_s2_data <= w_swapped;
        r_s2_sop  <= r_s1_sop;
        r_s2_eop  <= r_s1_eop;
      end
      if (r_s1_dvalid) r_s2_desc <= r_s1_desc;
      if (r_s2_valid) begin
        r_s3_data <= r_s2_data;
        r_s3_sop  <= r_s2_sop;
        r_s3_eop  <= r_s2_eop;
      end
      if (r_s2_dvalid) r_s3_desc <= r_s2_desc;
    end
  end

  assign pkt_buf_wr_en    = r_s3_valid;
  assign pkt_buf_wr_data  = r_s3_data;
  assign pkt_buf_wr_sop   = r_s3_sop;
  assign pkt_buf_wr_eop   = r_s3_eop;
  assign desc_buf_wr_en   = r_s3_dvalid;
  assign desc_buf_wr_data = r_s3_desc;
  assign stat_pkt_cnt     = r_stat_pkt;
  assign stat_trunc_cnt   = r_stat_trunc;
  assign stat_err_cnt     = r_stat_err;

endmodule

`default_nettype wire

// File: tb/tb_pdu_gen_mc.sv
// ============================================================================
// Module      : tb_pdu_gen_mc
// Description : Randomized self-checking bench for pdu_gen_mc with a
//               packet-level reference model (queues of expected writes and
//               descriptors tagged with the cycle they must appear in).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdu_gen_mc;
  import shared_struct_pkg::*;
  import pdu_pkg::*;

  localparam int DW     = 512;
  localparam int BPF    = DW / 8;
  localparam int EW     = $clog2(BPF);
  localparam int AW     = 10;
  localparam int DEPTH  = 1024;
  localparam int MAXF   = 24;
  localparam int SLACK  = 4;
  localparam int PKT_TH = DEPTH - SLACK - MAXF;
  localparam int DSC_TH = DEPTH - SLACK - 1;

  logic          clk, rst;
  logic          in_sop, in_eop, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [EW-1:0] in_empty;
  logic          in_meta_valid, in_meta_ready;
  metadata_t     in_meta_data;
  logic          pkt_buf_wr_en, pkt_buf_wr_sop, pkt_buf_wr_eop;
  logic [DW-1:0] pkt_buf_wr_data;
  logic [AW-1:0] pkt_buf_occup, desc_buf_occup;
  logic          desc_buf_wr_en;
  pdu_desc_t     desc_buf_wr_data;
  logic [31:0]   stat_pkt_cnt, stat_trunc_cnt, stat_err_cnt;

  pdu_gen_mc #(
    .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .PDU_AWIDTH(AW), .PDU_DEPTH(DEPTH),
    .MAX_PKT_FLITS(MAXF), .SWAP_BYTES(1), .PIPE_SLACK(SLACK)
  ) dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
    .in_data(in_data), .in_empty(in_empty), .in_ready(in_ready),
    .in_meta_valid(in_meta_valid), .in_meta_data(in_meta_data),
    .in_meta_ready(in_meta_ready),
    .pkt_buf_wr_en(pkt_buf_wr_en), .pkt_buf_wr_data(pkt_buf_wr_data),
    .pkt_buf_wr_sop(pkt_buf_wr_sop), .pkt_buf_wr_eop(pkt_buf_wr_eop),
    .pkt_buf_occup(pkt_buf_occup),
    .desc_buf_wr_en(desc_buf_wr_en), .desc_buf_wr_data(desc_buf_wr_data),
    .desc_buf_occup(desc_buf_occup),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_trunc_cnt(stat_trunc_cnt),
    .stat_err_cnt(stat_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic sop; logic eop; logic [EW-1:0] empty; } flit_t;
  typedef struct { int cyc; logic [DW-1:0] data; logic sop; logic eop; } wr_t;
  typedef struct { int cyc; pdu_desc_t d; } dsc_t;

  flit_t gen_q[$];
  wr_t   exp_wr[$];
  dsc_t  exp_dsc[$];

  int          n_chk, n_fail, cyc;
  int          m_mode;          // 0: between packets, 1: inside a packet, 2: dropping the tail
  int          m_cnt;
  logic [31:0] m_pkt, m_trunc, m_err;
  logic        first_pkt;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Packet generator: ordinary packets, oversize packets, stray non-sop
  // flits and packets carrying a spurious mid-packet sop.
  task automatic gen_packet();
    int kind, len, midsop;
    flit_t f;
    kind   = first_pkt ? 9 : int'($urandom_range(0, 9));
    midsop = -1;
    if (kind == 0) begin
      f.data = rand_data(); f.sop = 1'b0; f.eop = 1'($urandom_range(0, 1));
      f.empty = '0;
      gen_q.push_back(f);
      return;
    end
    if (first_pkt)      len = 3;
    else if (kind == 1) len = int'($urandom_range(25, 30));
    else                len = int'($urandom_range(1, 8));
    if (kind == 2 && len >= 2) midsop = int'($urandom_range(1, len - 1));
    for (int i = 0; i < len; i++) begin
      f.data  = rand_data();
      f.sop   = (i == 0) || (i == midsop);
      f.eop   = (i == len - 1);
      f.empty = f.eop ? (first_pkt ? EW'(10) : EW'($urandom_range(0, BPF - 1))) : '0;
      gen_q.push_back(f);
    end
    first_pkt = 1'b0;
  endtask

  // Reference behaviour for one accepted flit; returns whether metadata pops.
  task automatic model_step(input flit_t f, input metadata_t md, output logic pop);
    logic          writes, last, trunc;
    logic [DW-1:0] sw;
    wr_t           w;
    dsc_t          d;
    pop    = 1'b0;
    writes = (m_mode == 0 && f.sop) || (m_mode == 1);
    if (m_mode == 0 && !f.sop) m_err++;
    if (m_mode == 1 && f.sop)  m_err++;
    if (m_mode == 2) begin
      if (f.eop) m_mode = 0;
    end else if (writes) begin
      m_cnt  = (m_mode == 0) ? 1 : m_cnt + 1;
      last   = f.eop || (m_cnt == MAXF);
      trunc  = !f.eop && (m_cnt == MAXF);
      sw     = {<<8{f.data}};
      w.cyc  = cyc + 3; w.data = sw; w.sop = (m_mode == 0); w.eop = last;
      exp_wr.push_back(w);
      if (last) begin
        pop                 = 1'b1;
        d.cyc               = cyc + 3;
        d.d.dsc_queue_id    = md.dsc_queue_id[APP_IDX_WIDTH-1:0];
        d.d.pkt_queue_id    = md.pkt_queue_id[FLOW_IDX_WIDTH-1:0];
        d.d.size_flits      = 8'(m_cnt);
        d.d.size_bytes      = 16'(m_cnt * BPF - (trunc ? 0 : int'(f.empty)));
        d.d.trunc           = trunc;
        exp_dsc.push_back(d);
        m_pkt++;
        if (trunc) m_trunc++;
        m_mode = trunc ? 2 : 0;
      end else begin
        m_mode = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_en;
    wr_t  w;
    dsc_t d;
    exp_en = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
    chk("wr_en", pkt_buf_wr_en, exp_en);
    if (exp_en) begin
      w = exp_wr.pop_front();
      if (pkt_buf_wr_en) begin
        chk("wr_data", pkt_buf_wr_data, w.data);
        chk("wr_sop", pkt_buf_wr_sop, w.sop);
        chk("wr_eop", pkt_buf_wr_eop, w.eop);
      end
    end
    exp_en = (exp_dsc.size() > 0) && (exp_dsc[0].cyc == cyc);
    chk("desc_en", desc_buf_wr_en, exp_en);
    if (exp_en) begin
      d = exp_dsc.pop_front();
      if (desc_buf_wr_en) chk("desc_data", desc_buf_wr_data, d.d);
    end
    chk("stat_pkt", stat_pkt_cnt, m_pkt);
    chk("stat_trunc", stat_trunc_cnt, m_trunc);
    chk("stat_err", stat_err_cnt, m_err);
  endtask

  task automatic run_cycles(input int n, input logic drain);
    logic exp_ready, pop, xfer;
    int   r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check_outputs();
      if (gen_q.size() == 0) gen_packet();
      in_valid      = !drain && ($urandom_range(0, 9) < 8);
      in_sop        = gen_q[0].sop;
      in_eop        = gen_q[0].eop;
      in_data       = gen_q[0].data;
      in_empty      = gen_q[0].empty;
      in_meta_valid = ($urandom_range(0, 9) < 8);
      in_meta_data  = metadata_t'($urandom);
      r = int'($urandom_range(0, 19));
      pkt_buf_occup  = AW'($urandom_range(0, PKT_TH - 1));
      desc_buf_occup = AW'($urandom_range(0, DSC_TH - 1));
      if (r == 0) pkt_buf_occup  = AW'(PKT_TH);
      if (r == 1) pkt_buf_occup  = AW'(PKT_TH - 1);
      if (r == 2) desc_buf_occup = AW'(DSC_TH);
      if (r == 3) desc_buf_occup = AW'(DSC_TH - 1);
      if (r == 4) pkt_buf_occup  = AW'(DEPTH - 1);
      #1;
      exp_ready = !((int'(pkt_buf_occup) >= PKT_TH) || (int'(desc_buf_occup) >= DSC_TH))
                  && (m_mode == 2 || in_meta_valid);
      chk("in_ready", in_ready, exp_ready);
      xfer = in_valid && exp_ready;
      pop  = 1'b0;
      if (xfer) begin
        model_step(gen_q[0], in_meta_data, pop);
        void'(gen_q.pop_front());
      end
      chk("in_meta_ready", in_meta_ready, pop);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_wr_en"}, pkt_buf_wr_en, 1'b0);
    chk({tag, "_wr_data"}, pkt_buf_wr_data, '0);
    chk({tag, "_wr_sop_eop"}, {pkt_buf_wr_sop, pkt_buf_wr_eop}, 2'b00);
    chk({tag, "_desc_en"}, desc_buf_wr_en, 1'b0);
    chk({tag, "_desc_data"}, desc_buf_wr_data, '0);
    chk({tag, "_stats"}, {stat_pkt_cnt, stat_trunc_cnt, stat_err_cnt}, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_meta_ready"}, in_meta_ready, 1'b0);
  endtask

  task automatic clear_model();
    exp_wr.delete(); exp_dsc.delete(); gen_q.delete();
    m_mode = 0; m_cnt = 0; m_pkt = '0; m_trunc = '0; m_err = '0;
    first_pkt = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0; in_data = '0; in_empty = '0;
    in_meta_valid = 1'b1; in_meta_data = '0;
    pkt_buf_occup = '0; desc_buf_occup = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    run_cycles(1500, 1'b0);

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 500 && m_mode != 1; i++) run_cycles(1, 1'b0);
    chk("mid_pkt_reached", (m_mode == 1), 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    in_valid = 1'b1;
    in_meta_valid = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;

    run_cycles(1500, 1'b0);
    run_cycles(8, 1'b1);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("desc_queue_drained", exp_dsc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pdu_gen_mc.md
# pdu_gen_mc

Parametrised successor of the packet-to-PDU writer in the host RX path. It sits between the flow-director/metadata stage and the PCIe packet and descriptor buffers. It takes a flit stream plus per-packet metadata, writes flits into the packet buffer, and emits one descriptor per packet carrying both flit and byte size. Over its predecessor it adds:
- generic data width;
- optional byte swap;
- a correct valid/ready handshake;
- oversize truncation;
- framing-error recovery;
- statistics counters.

## Interface
Parameters:
- DATA_WIDTH, 512: flit width in bits; multiple of 8.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8): width of in_empty.
- PDU_AWIDTH, 10: occupancy width of both buffers.
- PDU_DEPTH, 1024: depth of both buffers.
- MAX_PKT_FLITS, 24: maximum flits per packet; longer packets are truncated.
- SWAP_BYTES, 1: 1 reverses byte order of each flit; 0 passes it through.
- PIPE_SLACK, 4: writes that can be in flight after in_ready deasserts.

Ports (async active-high reset):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- in_sop / in_eop / in_valid, in, 1 each, input flit framing.
- in_data, in, DATA_WIDTH, flit payload.
- in_empty, in, EMPTY_WIDTH, unused bytes on the eop flit.
- in_ready, out, 1, flit accept.
- in_meta_valid, in, 1, metadata available.
- in_meta_data, in, metadata_t, per-packet metadata.
- in_meta_ready, out, 1, metadata pop.
- pkt_buf_wr_en, out, 1, packet-buffer write strobe.
- pkt_buf_wr_data, out, DATA_WIDTH, flit written to the packet buffer.
- pkt_buf_wr_sop / pkt_buf_wr_eop, out, 1 each, framing of the written flit.
- pkt_buf_occup, in, PDU_AWIDTH, packet-buffer occupancy.
- desc_buf_wr_en, out, 1, descriptor write strobe.
- desc_buf_wr_data, out, pdu_desc_t, descriptor.
- desc_buf_occup, in, PDU_AWIDTH, descriptor-buffer occupancy.
- stat_pkt_cnt / stat_trunc_cnt / stat_err_cnt, out, 32 each, statistics counters.

## Operation
- almost_full is asserted when either condition holds:
  - pkt_buf_occup ≥ PDU_DEPTH − PIPE_SLACK − MAX_PKT_FLITS;
  - desc_buf_occup ≥ PDU_DEPTH − PIPE_SLACK − 1.
- in_ready = !almost_full && (state==DISCARD || in_meta_valid). It is combinational. A transfer is in_valid && in_ready.
- FSM states: IDLE, IN_PKT, DISCARD. Reset state is IDLE.
  - IDLE, transfer with sop: write the flit, set flit_cnt=1, go to IN_PKT. If the flit also has eop, close the packet and stay in IDLE.
  - IDLE, transfer without sop: drop the flit, stat_err_cnt+1.
  - IN_PKT, transfer: write the flit and increment flit_cnt.
    - A mid-packet sop is ignored (flit treated as continuation) and counts stat_err_cnt+1.
    - eop closes the packet and returns to IDLE.
  - IN_PKT, non-eop flit that makes flit_cnt==MAX_PKT_FLITS: force eop on it, close the packet with trunc=1, stat_trunc_cnt+1, go to DISCARD.
  - DISCARD: consume flits without writing; eop returns to IDLE. Metadata is neither required nor popped.
- Closing a packet:
  - in_meta_ready=1 combinationally in the same cycle as the closing transfer, so exactly one metadata pop per packet.
  - Emit one descriptor:
    - dsc_queue_id and pkt_queue_id, truncated to APP_IDX_WIDTH and FLOW_IDX_WIDTH;
    - size_flits = final flit_cnt;
    - size_bytes = size_flits·(DATA_WIDTH/8) − in_empty, or without subtraction when trunc;
    - trunc flag.
  - stat_pkt_cnt+1.
- Arithmetic and widths:
  - flit_cnt is $clog2(MAX_PKT_FLITS+1) bits.
  - size_bytes is 16 bits; compute it at full width, then truncate.
  - Counters wrap modulo 2^32.
- Swap (SWAP_BYTES=1): output byte i = input byte (DATA_WIDTH/8 − 1 − i).

## Timing
- Write pipeline is 3 register stages.
  - A flit accepted at edge k appears on pkt_buf_* with wr_en=1 in the cycle after edge k+2.
  - The packet's descriptor appears with desc_buf_wr_en=1 in that same cycle as its last flit's write.
- Throughput: one flit per cycle, no bubbles at packet boundaries.
- Reset (asynchronous) clears all of the following to 0, including mid-packet: pipeline valids, wr_en outputs, pkt_buf_wr_data, desc_buf_wr_data, counters, flit_cnt; FSM returns to IDLE.
  - Flits already written before reset are not retracted; the buffer owner resets too.
- in_ready and in_meta_ready read 0 while rst is high.
- A ready drop with flits in flight: up to 3 pipeline writes still land. PIPE_SLACK covers them.

## Structure
- pdu_pkg holds:
  - pdu_desc_t {dsc_queue_id, pkt_queue_id, size_flits, size_bytes, trunc};
  - APP_IDX_WIDTH, FLOW_IDX_WIDTH;
  - the state enum.
- metadata_t stays in the existing shared struct file.
- Sub-module pdu_byte_swap: combinational, parameterised by DATA_WIDTH and SWAP_BYTES; instantiated between stage 1 and stage 2.

## Test plan
- 3-flit packet, DATA_WIDTH=512, in_empty=10:
  - 3 writes, sop on the first and eop on the last, first write 3 cycles after the accept edge;
  - descriptor size_flits=3, size_bytes=182, trunc=0;
  - one in_meta_ready pulse.
- 30-flit packet, MAX_PKT_FLITS=24:
  - 24 writes, eop forced on the 24th;
  - descriptor size_bytes=1536, trunc=1;
  - 6 flits consumed and discarded without a metadata pop; stat_trunc_cnt=1.
- Framing errors: a non-sop flit in IDLE, then a packet with a mid-packet sop → one packet descriptor, stat_err_cnt=2.
- Backpressure:
  - drive pkt_buf_occup to the threshold mid-packet → in_ready=0 the same cycle, at most 3 further writes;
  - release → the stream resumes with byte-exact data.
- in_meta_valid=0 with in_valid=1 in IDLE → in_ready=0, nothing written.
- Reset mid-packet → all outputs 0 immediately (async); the next sop packet is processed correctly, counters restart at 0.
